mult_div_unit: RTL and testbench

Iterative signed multiply/divide engine with HI/LO registers for the multicycle MIPS core.
- The control unit issues MULT/DIV via a start/done handshake and holds its state machine in a wait state while busy.
- MFHI/MFLO read hi/lo directly.
- MTHI/MTLO write hi/lo through a write port.

---
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide engine with HI/LO registers.
// MULT uses shift-add and DIV uses restoring division, both on unsigned
// magnitudes. Each takes WIDTH iteration cycles plus one sign-fix cycle.
//
// Handshake: start/op/src_a/src_b are sampled only while busy is low (IDLE).
// An accepted start raises busy on the following cycle. Completion is a
// single-cycle done pulse, and hi/lo hold the new result from that cycle on.
// busy is already low in the done cycle, so a new start may be presented
// there. A DIV by zero skips iteration. It answers with done and div_zero
// together on the next cycle and leaves hi/lo untouched.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic             op_r;      // 0 = MULT, 1 = DIV
   logic             neg_res;   // product sign, or quotient sign (a ^ b)
   logic             neg_rem;   // remainder sign (dividend negative)
   logic [WIDTH-1:0] opnd;      // multiplicand (MULT) or divisor (DIV) magnitude
   logic [WIDTH-1:0] acc;       // upper product half, or partial remainder
   logic [WIDTH-1:0] q;         // multiplier/lower product, or dividend/quotient
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             done_r, dz_r;

   // Operand magnitudes and start qualification.
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             b_zero, accept, div0;

   // One iteration step for each operation.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] div_sh;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] acc_step, q_step;

   // Sign-corrected results.
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

   // Operand magnitudes and start decode.
   always_comb begin
      mag_a  = src_a[WIDTH-1] ? (~src_a + ONE_W) : src_a;
      mag_b  = src_b[WIDTH-1] ? (~src_b + ONE_W) : src_b;
      b_zero = (src_b == '0);
      accept = (state == IDLE) && start;
      div0   = accept && op && b_zero;
   end

   // Single iteration step. The remainder stays below the divisor
   // (at most 2^(WIDTH-1)), so the shifted remainder fits in WIDTH bits.
   always_comb begin
      mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
      div_sh   = {acc[WIDTH-2:0], q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {1'b0, opnd};
      acc_step = '0;
      q_step   = '0;
      if (op_r) begin
         acc_step = div_diff[WIDTH] ? div_sh : div_diff[WIDTH-1:0];
         q_step   = {q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
         acc_step = mul_sum[WIDTH:1];
         q_step   = {mul_sum[0], q[WIDTH-1:1]};
      end
   end

   // Sign correction applied in FIX.
   always_comb begin
      prod     = {acc, q};
      prod_fix = neg_res ? (~prod + ONE_2W) : prod;
      quo_fix  = neg_res ? (~q + ONE_W) : q;
      rem_fix  = neg_rem ? (~acc + ONE_W) : acc;
      res_hi   = op_r ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = op_r ? quo_fix : prod_fix[WIDTH-1:0];
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !(op && b_zero)) state_nxt = ITER;
         ITER:    if (cnt == CNT_LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Operand capture and iteration datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         op_r    <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         opnd    <= '0;
         acc     <= '0;
         q       <= '0;
      end else if (accept) begin
         cnt     <= '0;
         op_r    <= op;
         neg_res <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
         neg_rem <= src_a[WIDTH-1];
         opnd    <= op ? mag_b : mag_a;
         acc     <= '0;
         q       <= op ? mag_a : mag_b;
      end else if (state == ITER) begin
         cnt <= cnt + CNT_ONE;
         acc <= acc_step;
         q   <= q_step;
      end
   end

   // HI/LO: results land in FIX; MTHI/MTLO only when idle and not starting.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (state == FIX) begin
         hi_r <= res_hi;
         lo_r <= res_lo;
      end else if (state == IDLE && !start) begin
         if (wr_hi) hi_r <= wr_data;
         if (wr_lo) lo_r <= wr_data;
      end
   end

   // Completion pulses, each high for exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_r <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         done_r <= (state == FIX) || div0;
         dz_r   <= div0;
      end
   end

   assign busy     = (state != IDLE);
   assign done     = done_r;
   assign div_zero = dz_r;
   assign hi       = hi_r;
   assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit against hand-computed
// results, cycle-exact busy/done timing, HI/LO writes and reset abort.
module tb_mult_div_unit;

   logic        clk, rst, start, op, wr_hi, wr_lo;
   logic [31:0] src_a, src_b, wr_data;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] model_hi, model_lo;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Present a start request in the current cycle (cycle 0).
   task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
   endtask

   // Follow an accepted operation through cycle 34. Operands are scrambled
   // mid-run. If inj is non-zero, a start plus MTLO is presented in that cycle
   // and must be ignored.
   task automatic track(input string tag, input logic [31:0] eh, input logic [31:0] el,
                        input int inj);
      for (int k = 1; k <= 34; k++) begin
         step();
         start = 1'b0;
         wr_lo = 1'b0;
         if (k == 2) begin
            src_a = 32'h5A5A_1234;
            src_b = 32'hFFFF_0001;
         end
         if (k == inj) begin
            start   = 1'b1;
            op      = 1'b1;
            src_b   = 32'h0;
            wr_lo   = 1'b1;
            wr_data = 32'h0000_DEAD;
         end
         chk({tag, ".busy"}, 32'(busy), (k <= 33) ? 32'd1 : 32'd0);
         chk({tag, ".done"}, 32'(done), (k == 34) ? 32'd1 : 32'd0);
         if (k == 33) begin
            chk({tag, ".hi_hold"}, hi, model_hi);
            chk({tag, ".lo_hold"}, lo, model_lo);
         end
      end
      chk({tag, ".dz"}, 32'(div_zero), 32'd0);
      chk({tag, ".hi"}, hi, eh);
      chk({tag, ".lo"}, lo, el);
      model_hi = eh;
      model_lo = el;
   endtask

   // Directed sequence.
   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
      step();
      step();
      chk("rst.hi",   hi, 32'h0);
      chk("rst.lo",   lo, 32'h0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.dz",   32'(div_zero), 32'd0);
      rst = 1'b0;
      model_hi = 32'h0;
      model_lo = 32'h0;

      // Signed MULT, including the most-negative squared.
      issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
      track("mul_7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      issue(1'b0, 32'h8000_0000, 32'h8000_0000);
      track("mul_min_sq", 32'h4000_0000, 32'h0000_0000, 0);

      // DIV edge case and sign rules (truncate toward zero).
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      track("div_min_m1", 32'h0000_0000, 32'h8000_0000, 0);
      issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
      track("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
      track("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 0);

      // MTHI/MTLO preload, then divide by zero.
      wr_hi = 1'b1; wr_data = 32'h0000_1234;
      step();
      wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_5678;
      step();
      wr_lo = 1'b0;
      chk("mt.hi", hi, 32'h0000_1234);
      chk("mt.lo", lo, 32'h0000_5678);
      model_hi = 32'h0000_1234;
      model_lo = 32'h0000_5678;
      issue(1'b1, 32'h0000_0005, 32'h0000_0000);
      step();
      start = 1'b0;
      chk("dz.done1", 32'(done), 32'd1);
      chk("dz.dz1",   32'(div_zero), 32'd1);
      chk("dz.busy1", 32'(busy), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         step();
         chk("dz.done_after", 32'(done), 32'd0);
         chk("dz.dz_after",   32'(div_zero), 32'd0);
         chk("dz.busy_after", 32'(busy), 32'd0);
      end
      chk("dz.hi", hi, model_hi);
      chk("dz.lo", lo, model_lo);

      // Start and MTLO while busy are ignored; back-to-back start in done cycle.
      issue(1'b0, 32'h0000_0003, 32'h0000_0004);
      track("mul_3x4_inj", 32'h0000_0000, 32'h0000_000C, 10);
      issue(1'b0, 32'hFFFF_FFFB, 32'h0000_0006);
      track("mul_m5x6_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFE2, 0);

      // Reset in cycle 15 aborts the DIV with no done pulse.
      issue(1'b1, 32'd100, 32'd7);
      for (int k = 1; k <= 15; k++) begin
         step();
         start = 1'b0;
         if (k < 15) begin
            chk("abort.busy", 32'(busy), 32'd1);
            chk("abort.hi_hold", hi, model_hi);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort.busy16", 32'(busy), 32'd0);
      chk("abort.hi16",   hi, 32'h0);
      chk("abort.lo16",   lo, 32'h0);
      chk("abort.done16", 32'(done), 32'd0);
      model_hi = 32'h0;
      model_lo = 32'h0;
      for (int k = 17; k <= 40; k++) begin
         step();
         chk("abort.no_done", 32'(done), 32'd0);
         chk("abort.idle", 32'(busy), 32'd0);
      end
      issue(1'b1, 32'd100, 32'd7);
      track("div_100_7", 32'd2, 32'd14, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
